// File: rtl/ldl_fifo_pkg.sv
// Shared FIFO package: read-mode constants and pointer/count width helpers.
package ldl_fifo_pkg;
    localparam int LDL_AHEAD_STD  = 0;
    localparam int LDL_AHEAD_FWFT = 1;

    // Pointers carry one extra wrap bit so that full and empty can be told apart.
    function automatic int ptr_w(input int aw);
        return aw + 1;
    endfunction

    function automatic int cnt_w(input int aw);
        return aw + 2;
    endfunction
endpackage

// File: rtl/ldl_fifo_rs_v1_if.sv
// Read-side bundle of the FIFO: reader handshake, memory read port and pointer exchange.
interface ldl_fifo_rs_v1_if #(parameter int AW = 8, parameter int DW = 8);
    import ldl_fifo_pkg::*;
    logic                   re;
    logic                   empty;
    logic [DW-1:0]          dout;
    logic                   dvalid;
    logic                   me;
    logic [AW-1:0]          ra;
    logic [DW-1:0]          rd;
    logic [ptr_w(AW)-1:0]   w_pt;
    logic [ptr_w(AW)-1:0]   r_pt;
    logic [cnt_w(AW)-1:0]   rcnt;
    logic                   underflow;

    modport slave  (input  re, rd, w_pt,
                    output empty, dout, dvalid, me, ra, r_pt, rcnt, underflow);
    modport master (output re, rd, w_pt,
                    input  empty, dout, dvalid, me, ra, r_pt, rcnt, underflow);
endinterface

// File: rtl/ldl_fifo_prefetch.sv
// Show-ahead stage: one read in flight plus output and skid registers (at most two words held).
module ldl_fifo_prefetch #(parameter int DW = 8) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_ne_i,
    input  logic          pop_i,
    input  logic [DW-1:0] rd_i,
    output logic          me_o,
    output logic          ov_o,
    output logic [DW-1:0] dout_o,
    output logic [1:0]    n_o
);
    logic          f1_q, f1_d, ov_q, ov_d, sk_q, sk_d;
    logic [DW-1:0] out_q, out_d, skid_q, skid_d;

    assign n_o    = 2'(f1_q) + 2'(ov_q) + 2'(sk_q);
    // pop implies ov_q, so n_o - pop never goes negative.
    assign me_o   = mem_ne_i & ~rst & ((n_o - {1'b0, pop_i}) < 2'd2);
    assign f1_d   = me_o;
    assign ov_o   = ov_q;
    assign dout_o = out_q;

    always_comb begin
        ov_d   = ov_q;
        sk_d   = sk_q;
        out_d  = out_q;
        skid_d = skid_q;
        if (pop_i) begin
            if (sk_q) begin
                out_d = skid_q;
                sk_d  = 1'b0;
            end else begin
                ov_d  = 1'b0;
            end
        end
        // f1 and sk are never both set, so a returning word cannot collide with a skid move.
        if (f1_q) begin
            if ((!ov_q || pop_i) && !sk_q) begin
                out_d = rd_i;
                ov_d  = 1'b1;
            end else begin
                skid_d = rd_i;
                sk_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f1_q   <= 1'b0;
            ov_q   <= 1'b0;
            sk_q   <= 1'b0;
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            f1_q   <= f1_d;
            ov_q   <= ov_d;
            sk_q   <= sk_d;
            out_q  <= out_d;
            skid_q <= skid_d;
        end
    end
endmodule

// File: rtl/ldl_fifo_rs_v1.sv
// FIFO read side (standard or show-ahead). Define LDL_FIFO_RS_UNDERFLOW_EN for a sticky underflow flag.
module ldl_fifo_rs_v1
    import ldl_fifo_pkg::*;
#(
    parameter int AW    = 8,
    parameter int DW    = 8,
    parameter int AHEAD = LDL_AHEAD_FWFT
) (
    input  logic             clk,
    input  logic             rst,
    ldl_fifo_rs_v1_if.slave  bus
);
    localparam int PW = ptr_w(AW);
    localparam int CW = cnt_w(AW);

    logic [PW-1:0] r_pt_q, r_pt_d;
    logic          mem_ne, pop, adv;
    logic [1:0]    n;

    assign mem_ne = bus.w_pt != r_pt_q;
    assign pop    = bus.re & ~bus.empty;
    assign r_pt_d = r_pt_q + PW'(adv);

    generate
        if (AHEAD == LDL_AHEAD_FWFT) begin : g_fwft
            logic          me_w, ov_w;
            logic [DW-1:0] dout_w;

            ldl_fifo_prefetch #(.DW(DW)) u_prefetch (
                .clk      (clk),
                .rst      (rst),
                .mem_ne_i (mem_ne),
                .pop_i    (pop),
                .rd_i     (bus.rd),
                .me_o     (me_w),
                .ov_o     (ov_w),
                .dout_o   (dout_w),
                .n_o      (n)
            );
            // Pointer advances on every memory fetch, not on pop.
            assign adv        = me_w;
            assign bus.me     = me_w;
            assign bus.empty  = ~ov_w;
            assign bus.dvalid = ov_w;
            assign bus.dout   = dout_w;
        end else begin : g_std
            logic dvalid_q;

            always_ff @(posedge clk) begin
                if (rst) dvalid_q <= 1'b0;
                else     dvalid_q <= pop;
            end
            assign n          = 2'd0;
            assign adv        = pop & ~rst;
            assign bus.me     = adv;
            assign bus.empty  = ~mem_ne;
            assign bus.dvalid = dvalid_q;
            assign bus.dout   = bus.rd;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) r_pt_q <= '0;
        else     r_pt_q <= r_pt_d;
    end

    assign bus.ra   = r_pt_q[AW-1:0];
    assign bus.r_pt = r_pt_q;
    assign bus.rcnt = {1'b0, PW'(bus.w_pt - r_pt_q)} + CW'(n);

`ifdef LDL_FIFO_RS_UNDERFLOW_EN
    logic underflow_q;

    always_ff @(posedge clk) begin
        if (rst)                     underflow_q <= 1'b0;
        else if (bus.re & bus.empty) underflow_q <= 1'b1;
    end
    assign bus.underflow = underflow_q;
`else
    assign bus.underflow = 1'b0;
`endif
endmodule

// File: tb/tb_ldl_fifo_rs_v1.sv
// Directed bench: show-ahead and standard-read instances, each with a 1-cycle-latency memory model.
module tb_ldl_fifo_rs_v1;
    import ldl_fifo_pkg::*;
    localparam int AW = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ldl_fifo_rs_v1_if #(.AW(AW), .DW(DW)) if1(), if0();

    ldl_fifo_rs_v1 #(.AW(AW), .DW(DW), .AHEAD(LDL_AHEAD_FWFT)) dut1 (
        .clk(clk), .rst(rst), .bus(if1.slave));
    ldl_fifo_rs_v1 #(.AW(AW), .DW(DW), .AHEAD(LDL_AHEAD_STD)) dut0 (
        .clk(clk), .rst(rst), .bus(if0.slave));

    logic [DW-1:0] mem1 [16];
    logic [DW-1:0] mem0 [16];

    always @(posedge clk) begin
        if (if1.me) if1.rd <= mem1[if1.ra];
        if (if0.me) if0.rd <= mem0[if0.ra];
    end

    int n_chk  = 0;
    int n_pass = 0;
    logic uf_exp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [DW-1:0] d);
        mem1[if1.w_pt[AW-1:0]] = d;
        if1.w_pt = if1.w_pt + 5'd1;
    endtask

    initial begin
`ifdef LDL_FIFO_RS_UNDERFLOW_EN
        uf_exp = 1'b1;
`else
        uf_exp = 1'b0;
`endif
        if1.re = 1'b0; if1.w_pt = '0;
        if0.re = 1'b0; if0.w_pt = '0;
        rst = 1'b1;
        repeat (2) step();

        // reset state
        @(negedge clk);
        chk("rst_empty",  if1.empty, 1);
        chk("rst_dvalid", if1.dvalid, 0);
        chk("rst_me",     if1.me, 0);
        chk("rst_rpt",    if1.r_pt, 0);
        chk("rst_rcnt",   if1.rcnt, 0);
        chk("rst_uf",     if1.underflow, 0);
        chk("rst_dout",   if1.dout, 0);
        step();
        rst = 1'b0;
        step();

        // first-word latency
        push1(8'h11);
        @(negedge clk);
        chk("t1_me_c",     if1.me, 1);
        chk("t1_empty_c",  if1.empty, 1);
        step();
        @(negedge clk);
        chk("t1_me_c1",    if1.me, 0);
        chk("t1_empty_c1", if1.empty, 1);
        step();
        @(negedge clk);
        chk("t1_empty_c2", if1.empty, 0);
        chk("t1_dout",     if1.dout, 8'h11);
        chk("t1_rcnt",     if1.rcnt, 1);
        if1.re = 1'b1;
        step();
        if1.re = 1'b0;
        @(negedge clk);
        chk("t1_pop_empty", if1.empty, 1);
        chk("t1_pop_rcnt",  if1.rcnt, 0);

        // 16 words, prefetch limit then back-to-back drain
        rst = 1'b1; if1.w_pt = '0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) mem1[i] = 8'(i);
        if1.w_pt = 5'd16;
        begin
            int mecnt = 0;
            repeat (6) begin
                @(negedge clk);
                if (if1.me) mecnt++;
                step();
            end
            chk("t2_me_cnt", mecnt, 2);
        end
        @(negedge clk);
        chk("t2_rcnt",  if1.rcnt, 16);
        chk("t2_rpt",   if1.r_pt, 2);
        chk("t2_empty", if1.empty, 0);
        step();
        if1.re = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("t2_dout",  if1.dout, i);
            chk("t2_bubble", if1.empty, 0);
            step();
        end
        if1.re = 1'b0;
        @(negedge clk);
        chk("t2_end_empty", if1.empty, 1);
        chk("t2_end_rcnt",  if1.rcnt, 0);
        step();

        // pointer wrap: advance r_pt to 0x1E, then 4 words across the wrap
        for (int i = 0; i < 14; i++) push1(8'hF0 + 8'(i));
        if1.re = 1'b1;
        for (int k = 0; k < 64 && !(if1.r_pt == 5'd30 && if1.empty); k++) step();
        if1.re = 1'b0;
        chk("t3_drain_rpt",   if1.r_pt, 5'h1E);
        chk("t3_drain_empty", if1.empty, 1);
        for (int i = 0; i < 4; i++) push1(8'hA0 + 8'(i));
        chk("t3_wpt", if1.w_pt, 5'h02);
        for (int k = 0; k < 10 && if1.empty; k++) step();
        chk("t3_ready", if1.empty, 0);
        if1.re = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_dout", if1.dout, 8'hA0 + 8'(i));
            step();
        end
        if1.re = 1'b0;
        @(negedge clk);
        chk("t3_rpt",   if1.r_pt, 5'h02);
        chk("t3_empty", if1.empty, 1);
        chk("t3_rcnt",  if1.rcnt, 0);
        step();

        // pop while empty
        if1.re = 1'b1;
        @(negedge clk);
        chk("t4_me", if1.me, 0);
        step();
        if1.re = 1'b0;
        @(negedge clk);
        chk("t4_uf",   if1.underflow, uf_exp);
        chk("t4_rpt",  if1.r_pt, 5'h02);
        chk("t4_dout", if1.dout, 8'hA3);
        step();
        @(negedge clk);
        chk("t4_uf_sticky", if1.underflow, uf_exp);
        step();

        // reset with a read in flight and the output register full
        push1(8'h55);
        push1(8'h66);
        @(negedge clk);
        chk("t6_me0", if1.me, 1);
        step();
        @(negedge clk);
        chk("t6_me1", if1.me, 1);
        step();
        @(negedge clk);
        chk("t6_dvalid_pre", if1.dvalid, 1);
        chk("t6_rcnt_pre",   if1.rcnt, 2);
        rst = 1'b1; if1.w_pt = '0;
        step();
        @(negedge clk);
        chk("t6_empty", if1.empty, 1);
        chk("t6_rcnt",  if1.rcnt, 0);
        chk("t6_rpt",   if1.r_pt, 0);
        chk("t6_me",    if1.me, 0);
        chk("t6_uf",    if1.underflow, 0);
        rst = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("t6_stale_empty",  if1.empty, 1);
        chk("t6_stale_dvalid", if1.dvalid, 0);
        step();

        // standard read mode
        mem0[0] = 8'h31; mem0[1] = 8'h32; mem0[2] = 8'h33;
        if0.w_pt = 5'd3;
        for (int i = 0; i < 3; i++) begin
            if0.re = 1'b1;
            @(negedge clk);
            chk("t5_me", if0.me, 1);
            chk("t5_ra", if0.ra, i);
            if (i > 0) begin
                chk("t5_dvalid", if0.dvalid, 1);
                chk("t5_dout",   if0.dout, 8'h31 + 8'(i - 1));
            end
            step();
        end
        if0.re = 1'b0;
        @(negedge clk);
        chk("t5_dvalid_last", if0.dvalid, 1);
        chk("t5_dout_last",   if0.dout, 8'h33);
        chk("t5_rpt",         if0.r_pt, 3);
        chk("t5_empty",       if0.empty, 1);
        chk("t5_me_idle",     if0.me, 0);
        step();
        @(negedge clk);
        chk("t5_dvalid_off",  if0.dvalid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ldl_fifo_rs_v1.md
LDL_FIFO_RS_V1 -- requirements
Module: LDL_fifo_rs_v1

Interface
REQ-001 SHALL have parameter AW, default 8, memory address width; depth 2^AW.
REQ-002 SHALL have parameter DW, default 8, data width.
REQ-003 SHALL have parameter AHEAD, default 1; 1 = show-ahead (first-word-fall-through), 0 = standard read.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port re  input  1  reader pop request.
REQ-007 SHALL have port empty  output  1  no word available to reader.
REQ-008 SHALL have port dout  output  DW  read data.
REQ-009 SHALL have port dvalid  output  1  dout holds a valid word.
REQ-010 SHALL have port me  output  1  memory read enable.
REQ-011 SHALL have port ra  output  AW  memory read address, equal to r_pt[AW-1:0].
REQ-012 SHALL have port rd  input  DW  memory read data, valid the cycle after me.
REQ-013 SHALL have port w_pt  input  AW+1  write pointer from write side, same clock.
REQ-014 SHALL have port r_pt  output  AW+1  read pointer to write side.
REQ-015 SHALL have port rcnt  output  AW+2  words held by FIFO from the reader's view.
REQ-016 SHALL have port underflow  output  1  sticky pop-while-empty flag.

Function
REQ-017 SHALL define mem_ne = (w_pt != r_pt); pop = re & ~empty.
REQ-018 AHEAD=0: SHALL set empty = ~mem_ne, me = pop, r_pt += 1 on pop, dout = rd, dvalid = pop registered (1-cycle latency).
REQ-019 AHEAD=1: SHALL hold local state f1 (read in flight), ov (output reg full), sk (skid reg full); local occupancy n = f1+ov+sk, never above 2.
REQ-020 AHEAD=1: SHALL assert me, and increment r_pt, when mem_ne & (n - pop) < 2.
REQ-021 AHEAD=1: returning rd SHALL load output reg if output reg is empty or being popped and skid empty, else load skid; on pop with sk=1, skid moves to output reg the same edge.
REQ-022 AHEAD=1: SHALL set empty = ~ov, dvalid = ov, dout = output register.
REQ-023 AHEAD=1: first word latency SHALL be: mem_ne first true in cycle c -> me in c -> empty low in c+2.
REQ-024 SHALL keep data order strictly FIFO across skid, output reg and pointer wrap.
REQ-025 SHALL compute rcnt = (w_pt - r_pt) zero-extended + n (AHEAD=1) or + 0 (AHEAD=0).
REQ-026 r_pt SHALL wrap modulo 2^(AW+1); ra wraps modulo 2^AW.
REQ-027 re while empty SHALL be ignored: no pointer move, no me, dout unchanged.

Reset
REQ-028 On rst: r_pt=0, f1=ov=sk=0, dvalid=0, underflow=0, dout register=0; empty=1, me=0 the cycle after reset asserts.
REQ-029 rst mid-transfer SHALL discard in-flight rd, prefetched words and skid content.

Configuration
REQ-030 Macro LDL_FIFO_RS_UNDERFLOW_EN: defined -> underflow sets on re & empty and stays set until rst; undefined -> underflow tied 0, no flop.

Structure
REQ-031 Shared package LDL_fifo_pkg SHALL hold pointer-width helper functions and the AHEAD mode constants (LDL_AHEAD_STD=0, LDL_AHEAD_FWFT=1).
REQ-032 Show-ahead prefetch stage (f1/ov/sk, output and skid registers) SHALL be sub-module LDL_fifo_prefetch, instantiated only when AHEAD=1.

Verification (AW=4, DW=8)
REQ-033 AHEAD=1, write 0x11 to empty FIFO -> me in cycle c, empty low, dout=0x11 in c+2, rcnt=1.
REQ-034 AHEAD=1, write 16 words 0x00..0x0F, re held low -> me stops after 2 prefetches, rcnt=16, r_pt=2; then continuous re -> 0x00..0x0F one per cycle, no bubble, ends empty=1.
REQ-035 AHEAD=0, w_pt=3, re on 3 cycles -> me each cycle, ra=0,1,2, dvalid one cycle later each, r_pt=3, empty=1.
REQ-036 Pointer wrap: w_pt=r_pt=0x1E start, write 4, read 4 -> r_pt=0x02, data order intact.
REQ-037 re with empty, macro defined -> underflow=1 next cycle, sticky; r_pt unchanged; macro undefined -> underflow=0.
REQ-038 rst asserted with f1=1, ov=1 -> next cycle empty=1, rcnt=0, r_pt=0, stale rd not captured.
